// File: rtl/fifo_pkg.sv
// Shared helpers for the FIFO family: pointer width derivation and parameter
// legality predicates used at elaboration time.
package fifo_pkg;

   function automatic int addr_w_of(input int depth);
      int w;
      w = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < depth) w = i + 1;
      end
      return w;
   endfunction

   function automatic bit is_pow2(input int v);
      return (v >= 2) && ((v & (v - 1)) == 0);
   endfunction

   function automatic bit levels_ok(input int depth, input int af_level, input int ae_level);
      return (af_level >= 1) && (af_level <= depth) && (ae_level >= 0) && (ae_level <= depth - 1);
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: one synchronous write port, one asynchronous read port.
// Contents are never reset so the array can later become an SRAM wrapper.
module fifo_mem #(
   parameter int DATA_W = 12,
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              i_wr_en,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [DATA_W-1:0] i_wr_data,
   input  logic [ADDR_W-1:0] i_rd_addr,
   output logic [DATA_W-1:0] o_rd_data
);

   logic [DATA_W-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
   end

   assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/sync_fifo_ctl.sv
// Single-clock show-ahead FIFO using all DEPTH entries, with level flags,
// occupancy count, flush, and sticky overflow/underflow reporting.
module sync_fifo_ctl
   import fifo_pkg::*;
#(
   parameter  int DATA_W   = 12,
   parameter  int DEPTH    = 8,
   parameter  int AF_LEVEL = DEPTH - 1,
   parameter  int AE_LEVEL = 1,
   localparam int ADDR_W   = addr_w_of(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic [ADDR_W:0]   count,
   input  logic              err_clr,
   output logic              overflow,
   output logic              underflow
);

   generate
      if (!is_pow2(DEPTH) || !levels_ok(DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_params
         $error("sync_fifo_ctl: illegal DEPTH/AF_LEVEL/AE_LEVEL");
      end
   endgenerate

   localparam logic [ADDR_W:0] AF_L = (ADDR_W + 1)'(AF_LEVEL);
   localparam logic [ADDR_W:0] AE_L = (ADDR_W + 1)'(AE_LEVEL);

   logic [ADDR_W:0] r_wr_ptr;
   logic [ADDR_W:0] r_rd_ptr;
   logic            r_overflow;
   logic            r_underflow;

   logic [ADDR_W:0] w_count;
   logic            w_empty;
   logic            w_full;
   logic            w_rd_acc;
   logic            w_wr_acc;
   logic            w_ovf_set;
   logic            w_unf_set;

   // Extra wrap bit distinguishes full from empty when the indices match.
   assign w_count = r_wr_ptr - r_rd_ptr;
   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]) &&
                    (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]);

   // A read at full frees the slot the concurrent write lands in.
   assign w_rd_acc  = rd_en & ~w_empty & ~flush;
   assign w_wr_acc  = wr_en & (~w_full | rd_en) & ~flush;
   assign w_ovf_set = wr_en & w_full & ~rd_en & ~flush;
   assign w_unf_set = rd_en & w_empty & ~flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
         end else begin
            if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         r_overflow  <= w_ovf_set | (r_overflow  & ~err_clr);
         r_underflow <= w_unf_set | (r_underflow & ~err_clr);
      end
   end

   fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk       (clk),
      .i_wr_en   (w_wr_acc),
      .i_wr_addr (r_wr_ptr[ADDR_W-1:0]),
      .i_wr_data (wr_data),
      .i_rd_addr (r_rd_ptr[ADDR_W-1:0]),
      .o_rd_data (rd_data)
   );

   assign count        = w_count;
   assign empty        = w_empty;
   assign full         = w_full;
   assign almost_full  = (w_count >= AF_L);
   assign almost_empty = (w_count <= AE_L);
   assign overflow     = r_overflow;
   assign underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_ctl.sv
// Directed bench for sync_fifo_ctl (DATA_W=12, DEPTH=8, AF_LEVEL=7, AE_LEVEL=1):
// fill, drain, boundary simultaneous access, wrap, flush, error clear and reset.
module tb_sync_fifo_ctl;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        wr_en;
   logic [11:0] wr_data;
   logic        rd_en;
   logic [11:0] rd_data;
   logic        full;
   logic        empty;
   logic        almost_full;
   logic        almost_empty;
   logic [3:0]  count;
   logic        err_clr;
   logic        overflow;
   logic        underflow;

   int n_checks = 0;
   int n_errors = 0;

   logic [11:0] q[$];

   sync_fifo_ctl #(
      .DATA_W   (12),
      .DEPTH    (8),
      .AF_LEVEL (7),
      .AE_LEVEL (1)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush        (flush),
      .wr_en        (wr_en),
      .wr_data      (wr_data),
      .rd_en        (rd_en),
      .rd_data      (rd_data),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .count        (count),
      .err_clr      (err_clr),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, obs);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_cycle(input logic w, input logic r, input logic [11:0] d);
      wr_en   = w;
      rd_en   = r;
      wr_data = d;
      step();
      wr_en = 1'b0;
      rd_en = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_count"}, 32'(count), 32'd0);
      check({tag, "_empty"}, 32'(empty), 32'd1);
      check({tag, "_full"}, 32'(full), 32'd0);
      check({tag, "_ae"}, 32'(almost_empty), 32'd1);
      check({tag, "_af"}, 32'(almost_full), 32'd0);
      check({tag, "_ovf"}, 32'(overflow), 32'd0);
      check({tag, "_unf"}, 32'(underflow), 32'd0);
   endtask

   initial begin
      string      ops;
      logic [11:0] v;
      rst_n = 1'b0; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
      wr_data = '0; err_clr = 1'b0;
      #12;
      check_reset_state("reset");
      rst_n = 1'b1;

      // Fill 0x001..0x008
      for (int i = 1; i <= 8; i++) begin
         do_cycle(1'b1, 1'b0, 12'(i));
         check($sformatf("fill_count_%0d", i), 32'(count), 32'(i));
         if (i == 1) check("fill_ae_at_1", 32'(almost_empty), 32'd1);
         if (i == 2) check("fill_ae_at_2", 32'(almost_empty), 32'd0);
         if (i == 6) check("fill_af_at_6", 32'(almost_full), 32'd0);
         if (i == 7) check("fill_af_at_7", 32'(almost_full), 32'd1);
      end
      check("fill_full", 32'(full), 32'd1);
      check("fill_head", 32'(rd_data), 32'h001);
      do_cycle(1'b1, 1'b0, 12'h009);
      check("ovf_set", 32'(overflow), 32'd1);
      check("ovf_count", 32'(count), 32'd8);
      err_clr = 1'b1; step(); err_clr = 1'b0;
      check("ovf_clr", 32'(overflow), 32'd0);

      // Drain
      for (int i = 1; i <= 8; i++) begin
         check($sformatf("drain_data_%0d", i), 32'(rd_data), 32'(i));
         do_cycle(1'b0, 1'b1, 12'h000);
      end
      check("drain_empty", 32'(empty), 32'd1);
      do_cycle(1'b0, 1'b1, 12'h000);
      check("unf_set", 32'(underflow), 32'd1);
      check("unf_count", 32'(count), 32'd0);
      err_clr = 1'b1; rd_en = 1'b1; step(); err_clr = 1'b0; rd_en = 1'b0;
      check("unf_set_beats_clr", 32'(underflow), 32'd1);
      err_clr = 1'b1; step(); err_clr = 1'b0;
      check("unf_clr", 32'(underflow), 32'd0);

      // Simultaneous read/write at full
      for (int i = 1; i <= 8; i++) do_cycle(1'b1, 1'b0, 12'(i));
      do_cycle(1'b1, 1'b1, 12'hABC);
      check("sim_full_count", 32'(count), 32'd8);
      check("sim_full_full", 32'(full), 32'd1);
      check("sim_full_ovf", 32'(overflow), 32'd0);
      for (int i = 0; i < 7; i++) begin
         check($sformatf("sim_full_data_%0d", i), 32'(rd_data), 32'(i + 2));
         do_cycle(1'b0, 1'b1, 12'h000);
      end
      check("sim_full_abc", 32'(rd_data), 32'hABC);
      do_cycle(1'b0, 1'b1, 12'h000);
      check("sim_full_drained", 32'(empty), 32'd1);

      // Simultaneous read/write at empty
      do_cycle(1'b1, 1'b1, 12'h123);
      check("sim_empty_count", 32'(count), 32'd1);
      check("sim_empty_unf", 32'(underflow), 32'd1);
      check("sim_empty_data", 32'(rd_data), 32'h123);
      check("sim_empty_empty", 32'(empty), 32'd0);
      err_clr = 1'b1; step(); err_clr = 1'b0;
      q.delete();
      q.push_back(12'h123);

      // Wrap-around with count held in 3..5
      for (int i = 1; i <= 3; i++) begin
         do_cycle(1'b1, 1'b0, 12'(12'h200 + i));
         q.push_back(12'(12'h200 + i));
      end
      ops = "WRRWWRWRRWWRBBWRRWWR";
      v = 12'h300;
      for (int i = 0; i < ops.len(); i++) begin
         logic w, r;
         w = (ops[i] == "W") || (ops[i] == "B");
         r = (ops[i] == "R") || (ops[i] == "B");
         if (r) check($sformatf("wrap_data_%0d", i), 32'(rd_data), 32'(q[0]));
         do_cycle(w, r, v);
         if (r) void'(q.pop_front());
         if (w) q.push_back(v);
         v = v + 12'd1;
         check($sformatf("wrap_count_%0d", i), 32'(count), 32'(q.size()));
         check($sformatf("wrap_flags_%0d", i), {30'd0, full, empty}, 32'd0);
      end

      // Flush with overflow pending
      while (q.size() < 8) begin
         do_cycle(1'b1, 1'b0, v);
         q.push_back(v);
         v = v + 12'd1;
      end
      do_cycle(1'b1, 1'b0, 12'hFFF);
      check("pre_flush_ovf", 32'(overflow), 32'd1);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("pre_flush_data_%0d", i), 32'(rd_data), 32'(q[0]));
         do_cycle(1'b0, 1'b1, 12'h000);
         void'(q.pop_front());
      end
      check("pre_flush_count", 32'(count), 32'd5);
      flush = 1'b1; wr_en = 1'b1; wr_data = 12'h555; step();
      flush = 1'b0; wr_en = 1'b0;
      q.delete();
      check("flush_count", 32'(count), 32'd0);
      check("flush_empty", 32'(empty), 32'd1);
      check("flush_ovf_kept", 32'(overflow), 32'd1);
      err_clr = 1'b1; step(); err_clr = 1'b0;
      check("post_flush_clr", 32'(overflow), 32'd0);

      // Asynchronous reset in the middle of a write burst
      do_cycle(1'b1, 1'b0, 12'h3A5);
      check("pre_rst_count", 32'(count), 32'd1);
      wr_en = 1'b1; wr_data = 12'h3A6;
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_state("async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      step();
      wr_en = 1'b0;
      check("post_rst_count", 32'(count), 32'd1);
      check("post_rst_data", 32'(rd_data), 32'h3A6);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
